// File: rtl/neuron_pkg.sv
// neuron_pkg: shared widths, FSM states, result type and saturation for the neuron datapath
package neuron_pkg;
  localparam int DATA_W = 32;
  localparam int MAX_TERMS = 64;
  localparam int ACC_W = DATA_W + $clog2(MAX_TERMS) + 1;
  localparam int FRAC_W = DATA_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  typedef enum logic [1:0] {ACC, DRAIN, HOLD} state_e;
  typedef struct packed {
    logic sat;
    logic [DATA_W-1:0] data;
  } res_t;
  function automatic res_t saturate(input logic signed [ACC_W-1:0] acc, input logic relu);
    res_t r;
    r.sat = acc > SAT_MAX || acc < SAT_MIN;
    r.data = acc > SAT_MAX ? SAT_MAX[DATA_W-1:0] : acc < SAT_MIN ? SAT_MIN[DATA_W-1:0] : acc[DATA_W-1:0];
    r.data = relu && r.data[DATA_W-1] ? '0 : r.data;
    return r;
  endfunction
endpackage

// File: rtl/neuron_mac_if.sv
// neuron_mac_if: term stream in, result stream out
interface neuron_mac_if;
  import neuron_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] in_weight;
  logic in_last;
  logic relu_en;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_data;
  logic out_sat;
  modport master (
    output in_valid, in_data, in_weight, in_last, relu_en, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );
  modport slave (
    input  in_valid, in_data, in_weight, in_last, relu_en, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/neuron_mul.sv
// neuron_mul: one-stage registered sign-magnitude fixed-point multiplier, truncating toward zero
module neuron_mul #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 32,
  parameter int ACC_W = 39
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] weight_i,
  output logic valid_o,
  output logic signed [ACC_W-1:0] term_o
);
  logic [DATA_W-1:0] mag;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0] p_ext;
  logic signed [ACC_W-1:0] term_d, term_q;
  logic valid_q;
  assign mag = weight_i[DATA_W-1] ? -weight_i : weight_i;
  assign prod = (2*DATA_W)'(data_i) * (2*DATA_W)'(mag);
  assign p_ext = ACC_W'(prod >> FRAC_W);
  assign term_d = weight_i[DATA_W-1] ? -$signed(p_ext) : $signed(p_ext);
  assign valid_o = valid_q;
  assign term_o = term_q;
  // capture the signed term on accepted beats; valid follows one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      term_q <= '0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) term_q <= term_d;
    end
  end
endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: streaming multiply-accumulate neuron with saturation and optional ReLU
module neuron_mac
  import neuron_pkg::*;
(
  input logic clk,
  input logic rst,
  neuron_mac_if.slave bus
);
  state_e state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, term;
  logic term_vld, accept, hs, relu_q, relu_d, in_ready_q, out_valid_q, out_sat_q;
  logic [DATA_W-1:0] out_data_q;
  res_t res;
  assign accept = bus.in_valid && bus.in_ready;
  assign hs = state_q == HOLD && bus.out_ready;
  assign bus.in_ready = in_ready_q && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = out_data_q;
  assign bus.out_sat = out_sat_q;
  neuron_mul #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_mul (
    .clk(clk),
    .rst(rst),
    .valid_i(accept),
    .data_i(bus.in_data),
    .weight_i(bus.in_weight),
    .valid_o(term_vld),
    .term_o(term)
  );
  // next state, accumulation of the registered term, and the clipped result of the final sum
  always_comb begin
    state_d = accept && bus.in_last ? DRAIN : state_q == DRAIN ? HOLD : hs ? ACC : state_q;
    acc_d = hs ? '0 : term_vld ? acc_q + term : acc_q;
    relu_d = accept && bus.in_last ? bus.relu_en : relu_q;
    res = saturate(acc_d, relu_q);
  end
  // state, accumulator and output registers; the result is frozen when leaving DRAIN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC;
      acc_q <= '0;
      relu_q <= 1'b0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      relu_q <= relu_d;
      in_ready_q <= state_d == ACC;
      out_valid_q <= state_d == HOLD;
      if (state_q == DRAIN) begin
        out_data_q <= res.data;
        out_sat_q <= res.sat;
      end
    end
  end
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: table-driven and randomized check of neuron_mac against an arithmetic model
module tb_neuron_mac;
  logic clk = 1'b0;
  logic rst = 1'b1;
  neuron_mac_if bus();
  neuron_mac dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] vx[64];
  logic [31:0] vw[64];

  typedef struct {
    int n;
    logic [3:0][31:0] x;
    logic [3:0][31:0] w;
    bit relu;
    int stall;
    logic [31:0] d;
    bit s;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input int n, input bit relu, output logic [31:0] d, output bit s);
    longint acc = 0;
    for (int i = 0; i < n; i++) begin
      longint wv = longint'($signed(vw[i]));
      longint mag = wv < 0 ? -wv : wv;
      longint p = (longint'({32'h0, vx[i]}) * mag) / 64'sd4294967296;
      acc += wv < 0 ? -p : p;
    end
    s = 1'b0;
    if (acc > 64'sd2147483647) begin
      d = 32'h7FFF_FFFF;
      s = 1'b1;
    end else if (acc < -64'sd2147483648) begin
      d = 32'h8000_0000;
      s = 1'b1;
    end else d = acc[31:0];
    if (relu && d[31]) d = 32'h0;
  endfunction

  task automatic wait_accept(input string tag, input bit first);
    int k = 0;
    @(negedge clk);
    if (first) begin
      check({tag, "_ready_first"}, 64'(bus.in_ready), 64'd1);
      check({tag, "_idle_valid"}, 64'(bus.out_valid), 64'd0);
    end
    while (!bus.in_ready && k < 16) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_ready_timeout: in_ready stayed 0", tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_beats(input string tag, input int n, input bit last, input bit relu);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = vx[i];
      bus.in_weight = vw[i];
      bus.in_last = last && i == n - 1;
      bus.relu_en = (last && i == n - 1) ? relu : 1'($urandom);
      wait_accept(tag, i == 0);
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic run_vec(input string tag, input int n, input bit relu, input int stall,
                         input logic [31:0] ed, input bit es);
    send_beats(tag, n, 1'b1, relu);
    @(negedge clk);
    check({tag, "_drain_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_drain_ready"}, 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_data"}, 64'(bus.out_data), 64'(ed));
    check({tag, "_sat"}, 64'(bus.out_sat), 64'(es));
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check({tag, "_stall_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_stall_data"}, 64'(bus.out_data), 64'(ed));
      check({tag, "_stall_ready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] ed;
    bit es;
    tbl[0] = '{n:1, x:{4{32'h8000_0000}}, w:{4{32'h4000_0000}}, relu:0, stall:0, d:32'h2000_0000, s:0};
    tbl[1] = '{n:1, x:{4{32'h8000_0000}}, w:{4{32'hC000_0000}}, relu:0, stall:0, d:32'hE000_0000, s:0};
    tbl[2] = '{n:1, x:{4{32'h0000_0001}}, w:{4{32'hFFFF_FFFF}}, relu:0, stall:0, d:32'h0, s:0};
    tbl[3] = '{n:4, x:{4{32'hFFFF_FFFF}}, w:{4{32'h7FFF_FFFF}}, relu:0, stall:0, d:32'h7FFF_FFFF, s:1};
    tbl[4] = '{n:2, x:{64'h0, 32'h4000_0000, 32'h8000_0000}, w:{64'h0, 32'h8000_0000, 32'hC000_0000},
               relu:1, stall:5, d:32'h0, s:0};
    tbl[5] = '{n:2, x:{64'h0, 32'h4000_0000, 32'h8000_0000}, w:{64'h0, 32'h8000_0000, 32'hC000_0000},
               relu:0, stall:0, d:32'hC000_0000, s:0};
    tbl[6] = '{n:4, x:{4{32'hFFFF_FFFF}}, w:{4{32'h8000_0001}}, relu:0, stall:0, d:32'h8000_0000, s:1};
    tbl[7] = '{n:4, x:{4{32'hFFFF_FFFF}}, w:{4{32'h8000_0001}}, relu:1, stall:2, d:32'h0, s:1};
    tbl[8] = '{n:1, x:{4{32'hFFFF_FFFF}}, w:{4{32'h8000_0000}}, relu:0, stall:1, d:32'h8000_0001, s:0};
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_weight = '0;
    bus.in_last = 1'b0;
    bus.relu_en = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_sat", 64'(bus.out_sat), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int t = 0; t < 9; t++) begin
      for (int i = 0; i < tbl[t].n; i++) begin
        vx[i] = tbl[t].x[i];
        vw[i] = tbl[t].w[i];
      end
      run_vec($sformatf("tbl%0d", t), tbl[t].n, tbl[t].relu, tbl[t].stall, tbl[t].d, tbl[t].s);
    end

    for (int i = 0; i < 3; i++) begin
      vx[i] = $urandom;
      vw[i] = $urandom;
    end
    send_beats("rst_mid", 3, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mid_out_data", 64'(bus.out_data), 64'd0);
    check("rst_mid_out_sat", 64'(bus.out_sat), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    vx[0] = 32'h8000_0000;
    vw[0] = 32'hC000_0000;
    run_vec("post_rst", 1, 1'b0, 0, 32'hE000_0000, 1'b0);

    for (int r = 0; r < 12; r++) begin
      int n;
      bit relu;
      n = (r == 11) ? 64 : int'($urandom_range(1, 8));
      relu = 1'($urandom);
      for (int i = 0; i < n; i++) begin
        vx[i] = $urandom;
        vw[i] = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) vw[i] = -vw[i];
        if ($urandom_range(0, 15) == 0) vw[i] = 32'h8000_0000;
      end
      model(n, relu, ed, es);
      run_vec($sformatf("rnd%0d", r), n, relu, int'($urandom_range(0, 3)), ed, es);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
